// File: rtl/touch_key_debouncer_if.sv
// Touch-key bus: raw pin vector in, debounced one-hot key vector, level flags and strobes out.
// The master modport is the pin/consumer side; the slave modport is the debouncer.
interface touch_key_debouncer_if #(
  parameter int N_KEYS = 7
);
  logic [N_KEYS-1:0] pin_raw;
  logic [N_KEYS-1:0] pin_clean;
  logic              key_valid;
  logic              key_press;
  logic              key_release;
  logic              multi_err;

  modport master (
    output pin_raw,
    input  pin_clean, key_valid, key_press, key_release, multi_err
  );

  modport slave (
    input  pin_raw,
    output pin_clean, key_valid, key_press, key_release, multi_err
  );
endinterface

// File: rtl/touch_key_debouncer.sv
// Synchronises and debounces the touch-key pin vector as a whole, then classifies the
// committed vector as idle, single key or multi-key and drives clean key outputs.
module touch_key_debouncer #(
  parameter int N_KEYS          = 7,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  touch_key_debouncer_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    INVALID = 2'd2
  } state_e;

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              commit;
  logic              vec_zero, vec_onehot;

  state_e            state_q;
  logic [N_KEYS-1:0] pin_clean_q;
  logic              key_valid_q, key_press_q, key_release_q, multi_err_q;

  // Any change of the synchronised vector restarts the full count; at terminal the
  // counter holds and the candidate is re-committed every cycle while stable.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch is inferred.
    cand_d = cand_q;
    cnt_d  = cnt_q;
    commit = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_LAST) begin
      commit = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so the two sync stages shift rather than collapse into one.
      sync1_q <= bus.pin_raw;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign vec_zero   = (cand_q == '0);
  assign vec_onehot = $onehot(cand_q);

  // Transitions compare against the current state, so repeated commits of the same
  // stable vector never re-fire a strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pin_clean_q   <= '0;
      key_valid_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
      multi_err_q   <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle, which makes each pulse exactly one cycle.
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
      if (commit) begin
        case (state_q)
          IDLE: begin
            if (vec_onehot) begin
              state_q     <= PRESSED;
              pin_clean_q <= cand_q;
              key_valid_q <= 1'b1;
              key_press_q <= 1'b1;
            end else if (!vec_zero) begin
              state_q     <= INVALID;
              multi_err_q <= 1'b1;
            end
          end
          PRESSED: begin
            if (vec_zero) begin
              state_q       <= IDLE;
              pin_clean_q   <= '0;
              key_valid_q   <= 1'b0;
              key_release_q <= 1'b1;
            end else if (vec_onehot) begin
              if (cand_q != pin_clean_q) begin
                pin_clean_q <= cand_q;
                key_press_q <= 1'b1;
              end
            end else begin
              state_q       <= INVALID;
              pin_clean_q   <= '0;
              key_valid_q   <= 1'b0;
              multi_err_q   <= 1'b1;
              key_release_q <= 1'b1;
            end
          end
          INVALID: begin
            if (vec_zero) begin
              state_q     <= IDLE;
              multi_err_q <= 1'b0;
            end else if (vec_onehot) begin
              state_q     <= PRESSED;
              multi_err_q <= 1'b0;
              pin_clean_q <= cand_q;
              key_valid_q <= 1'b1;
              key_press_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.pin_clean   = pin_clean_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.key_press   = key_press_q;
  assign bus.key_release = key_release_q;
  assign bus.multi_err   = multi_err_q;

endmodule

// File: tb/tb_touch_key_debouncer.sv
// Directed scoreboard bench for touch_key_debouncer plus a random run checking output invariants.
module tb_touch_key_debouncer;

  localparam int N   = 7;
  localparam int D   = 4;
  localparam int LAT = 2 + D + 1;

  typedef struct {
    int           cyc;
    logic         press;
    logic         rel;
    logic [N-1:0] clean;
    logic         valid;
    logic         merr;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;
  int   n_press = 0;
  bit   sb_en = 1'b0;
  bit   inv_en = 1'b0;
  logic prev_press = 1'b0;
  logic prev_rel = 1'b0;
  ev_t  exp_q[$];
  ev_t  mon_e;

  touch_key_debouncer_if #(.N_KEYS(N)) bus ();

  touch_key_debouncer #(
    .N_KEYS(N), .DEBOUNCE_CYCLES(D), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v);
    bus.pin_raw = v;
  endtask

  task automatic expect_strobe(input logic press, input logic rel, input logic [N-1:0] clean,
                               input logic valid, input logic merr);
    ev_t e;
    e.cyc = cyc + LAT;
    e.press = press;
    e.rel = rel;
    e.clean = clean;
    e.valid = valid;
    e.merr = merr;
    exp_q.push_back(e);
  endtask

  task automatic check_levels(input string tag, input logic [N-1:0] clean, input logic valid,
                              input logic merr);
    check({tag, "_clean"}, 32'(bus.pin_clean), 32'(clean));
    check({tag, "_valid"}, 32'(bus.key_valid), 32'(valid));
    check({tag, "_merr"}, 32'(bus.multi_err), 32'(merr));
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Scoreboard monitor: every strobe must match the next queued expectation exactly.
  always @(negedge clk) begin
    if (sb_en && (bus.key_press || bus.key_release)) begin
      if (exp_q.size() == 0) begin
        check("spurious_strobe", 32'({bus.key_press, bus.key_release}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("strobe_press", 32'(bus.key_press), 32'(mon_e.press));
        check("strobe_release", 32'(bus.key_release), 32'(mon_e.rel));
        check("strobe_clean", 32'(bus.pin_clean), 32'(mon_e.clean));
        check("strobe_valid", 32'(bus.key_valid), 32'(mon_e.valid));
        check("strobe_merr", 32'(bus.multi_err), 32'(mon_e.merr));
      end
    end
    if (inv_en) begin
      check("inv_onehot0", 32'($onehot0(bus.pin_clean)), 32'd1);
      check("inv_valid_or", 32'(bus.key_valid), 32'(|bus.pin_clean));
      check("inv_strobe_excl", 32'(bus.key_press & bus.key_release), 32'd0);
      check("inv_press_width", 32'(bus.key_press & prev_press), 32'd0);
      check("inv_release_width", 32'(bus.key_release & prev_rel), 32'd0);
    end
    if (bus.key_press) n_press <= n_press + 1;
    prev_press <= bus.key_press;
    prev_rel   <= bus.key_release;
  end

  initial begin
    bus.pin_raw = '0;
    reset = 1'b1;
    step(3);
    check_levels("reset", '0, 1'b0, 1'b0);
    check("reset_press", 32'(bus.key_press), 32'd0);
    check("reset_release", 32'(bus.key_release), 32'd0);
    reset = 1'b0;
    sb_en = 1'b1;
    step(10);

    // Single key held: one press, no re-fire while held, then release.
    drive(7'b0010000);
    expect_strobe(1'b1, 1'b0, 7'b0010000, 1'b1, 1'b0);
    step(20);
    check_levels("t1_hold", 7'b0010000, 1'b1, 1'b0);
    check_drained("t1_press");
    drive('0);
    expect_strobe(1'b0, 1'b1, '0, 1'b0, 1'b0);
    step(12);
    check_drained("t1_release");

    // Bounce on bit 6 every 2 cycles, then hold: single press after the last change.
    for (int i = 0; i < 10; i++) begin
      drive((i % 2 == 0) ? 7'b1000000 : 7'b0000000);
      step(2);
    end
    drive(7'b1000000);
    expect_strobe(1'b1, 1'b0, 7'b1000000, 1'b1, 1'b0);
    step(12);
    check_drained("t2_bounce");

    // Direct switch to another key: press only.
    drive(7'b0000001);
    expect_strobe(1'b1, 1'b0, 7'b0000001, 1'b1, 1'b0);
    step(12);
    check_levels("t3_switch", 7'b0000001, 1'b1, 1'b0);
    check_drained("t3_switch");
    drive('0);
    expect_strobe(1'b0, 1'b1, '0, 1'b0, 1'b0);
    step(12);
    check_drained("t3_release");

    // Pressed -> multi-key: release pulse plus error; then release all silently.
    drive(7'b0000100);
    expect_strobe(1'b1, 1'b0, 7'b0000100, 1'b1, 1'b0);
    step(12);
    drive(7'b0000110);
    expect_strobe(1'b0, 1'b1, '0, 1'b0, 1'b1);
    step(12);
    check_levels("t4_multi", '0, 1'b0, 1'b1);
    check_drained("t4_multi");
    drive('0);
    step(12);
    check_levels("t4_clear", '0, 1'b0, 1'b0);

    // Idle -> multi (silent), multi -> other multi (stay), multi -> one-hot (press).
    drive(7'b0000011);
    step(12);
    check_levels("t4b_invalid", '0, 1'b0, 1'b1);
    drive(7'b0000111);
    step(12);
    check_levels("t4b_stay", '0, 1'b0, 1'b1);
    drive(7'b0000010);
    expect_strobe(1'b1, 1'b0, 7'b0000010, 1'b1, 1'b0);
    step(12);
    check_drained("t4b_recover");
    drive('0);
    expect_strobe(1'b0, 1'b1, '0, 1'b0, 1'b0);
    step(12);
    check_drained("t4b_release");

    // Reset while pressed: outputs clear silently, held key re-detected after full latency.
    drive(7'b0100000);
    expect_strobe(1'b1, 1'b0, 7'b0100000, 1'b1, 1'b0);
    step(12);
    check("t5_valid_before", 32'(bus.key_valid), 32'd1);
    check_drained("t5_press");
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_levels("t5_reset", '0, 1'b0, 1'b0);
    check("t5_reset_strobes", 32'({bus.key_press, bus.key_release}), 32'd0);
    expect_strobe(1'b1, 1'b0, 7'b0100000, 1'b1, 1'b0);
    step(12);
    check_drained("t5_redetect");
    drive('0);
    expect_strobe(1'b0, 1'b1, '0, 1'b0, 1'b0);
    step(12);
    check_drained("t5_release");

    // Random held patterns: invariants only.
    sb_en = 1'b0;
    inv_en = 1'b1;
    n_press = 0;
    begin
      int n = 0;
      while (n < 10000) begin
        int kind = $urandom_range(0, 2);
        int hold = $urandom_range(1, 14);
        case (kind)
          0:       drive('0);
          1:       drive(7'(1) << $urandom_range(0, N - 1));
          default: drive(7'($urandom));
        endcase
        step(hold);
        n += hold;
      end
    end
    inv_en = 1'b0;
    check("rnd_activity", 32'(n_press > 0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
